// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - 8N1 UART transmit sequencer draining a first-word-fall-through FIFO
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txEnable,
    input  logic       fifoEmpty,
    input  logic [7:0] fifoDo,
    output logic       fifoRe,
    output logic       txd,
    output logic       busy
);
    localparam int              TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   TLAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      ILAST = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          txd_nxt;
    logic          tick;

    assign tick = (timer == TLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shift <= '0;
            txd   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
            txd   <= txd_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // txd is computed one cycle ahead so the pin is driven straight from a flop
    always_comb begin
        state_nxt = state;
        timer_nxt = tick ? '0 : timer + 1'b1;
        idx_nxt   = idx;
        shift_nxt = shift;
        txd_nxt   = txd;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                txd_nxt   = 1'b1;
                if (fifoRe) begin
                    state_nxt = START;
                    shift_nxt = fifoDo;
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                    txd_nxt   = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    idx_nxt   = idx + 1'b1;
                    if (idx == ILAST) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        txd_nxt = shift[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    txd_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    always_comb begin
        fifoRe = (state == IDLE) & txEnable & ~fifoEmpty & ~reset;
    end

endmodule
